// File: rtl/multiplier_control_pkg.sv
// rtl/multiplier_control_pkg.sv - state encodings and helpers for the shift-and-add multiplier sequencer
package multiplier_control_pkg;

  localparam int IDLE = 0;
  localparam int INIT = 1;

  // Coarse class of a state value; the bit index is recovered separately.
  typedef enum logic [2:0] {
    KIND_IDLE,
    KIND_INIT,
    KIND_CHECK,
    KIND_ADD,
    KIND_SHIFT,
    KIND_DONE,
    KIND_ILLEGAL
  } state_kind_e;

  function automatic int check_enc(input int i);
    return 3 * i + 2;
  endfunction

  function automatic int add_enc(input int i);
    return 3 * i + 3;
  endfunction

  function automatic int shift_enc(input int i);
    return 3 * i + 4;
  endfunction

  function automatic int done_enc(input int width);
    return 3 * width + 2;
  endfunction

  function automatic int legal_count(input int width);
    return 3 * width + 3;
  endfunction

  // Map a state value onto its class; anything past DONE is illegal.
  function automatic state_kind_e classify(input int width, input int st);
    state_kind_e k;
    k = KIND_ILLEGAL;
    if (st == IDLE) begin
      k = KIND_IDLE;
    end else if (st == INIT) begin
      k = KIND_INIT;
    end else if (st == done_enc(width)) begin
      k = KIND_DONE;
    end else begin
      for (int i = 0; i < width; i++) begin
        if (st == check_enc(i)) k = KIND_CHECK;
        if (st == add_enc(i))   k = KIND_ADD;
        if (st == shift_enc(i)) k = KIND_SHIFT;
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/multiplier_control_decode.sv
// rtl/multiplier_control_decode.sv - Moore decoder from current state to datapath strobes and done
module multiplier_control_decode
  import multiplier_control_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int STATE_WIDTH = $clog2(legal_count(WIDTH))
) (
  input  logic [STATE_WIDTH-1:0] s,
  output logic                   mdld,
  output logic                   mrld,
  output logic                   rsload,
  output logic                   rsclear,
  output logic                   rsshr,
  output logic                   done
);

  state_kind_e kind;

  // Strobes depend only on the state class; CHECK, IDLE and illegal values drive nothing.
  always_comb begin
    kind    = classify(WIDTH, int'(s));
    mdld    = 1'b0;
    mrld    = 1'b0;
    rsload  = 1'b0;
    rsclear = 1'b0;
    rsshr   = 1'b0;
    done    = 1'b0;
    case (kind)
      KIND_INIT: begin
        mdld    = 1'b1;
        mrld    = 1'b1;
        rsclear = 1'b1;
      end
      KIND_ADD:   rsload = 1'b1;
      KIND_SHIFT: rsshr  = 1'b1;
      KIND_DONE:  done   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multiplier_control.sv
// rtl/multiplier_control.sv - shift-and-add multiplier sequencer FSM (option: MULTCTL_STATE_RECOVERY_EN)
module multiplier_control
  import multiplier_control_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int STATE_WIDTH = $clog2(legal_count(WIDTH))
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STATE_WIDTH-1:0] reset_state,
  input  logic                   start,
  input  logic [WIDTH-1:0]       mr,
  output logic                   mdld,
  output logic                   mrld,
  output logic                   rsload,
  output logic                   rsclear,
  output logic                   rsshr,
  output logic [STATE_WIDTH-1:0] s,
  output logic [STATE_WIDTH-1:0] n,
  output logic                   done
);

  logic [STATE_WIDTH-1:0] s_reg;
  int                     st_i;

  // State register; reset_state is a live input, so the visible state also
  // follows it combinationally for as long as rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_reg <= reset_state;
    else     s_reg <= n;
  end

  assign s    = rst ? reset_state : s_reg;
  assign st_i = int'(s);

  // Next-state: walk the multiplier bits LSB-first, adding only where mr[i] is set.
  always_comb begin
`ifdef MULTCTL_STATE_RECOVERY_EN
    n = STATE_WIDTH'(IDLE);
`else
    n = s;
`endif
    if (st_i == IDLE) begin
      n = start ? STATE_WIDTH'(INIT) : STATE_WIDTH'(IDLE);
    end else if (st_i == INIT) begin
      n = STATE_WIDTH'(check_enc(0));
    end else if (st_i == done_enc(WIDTH)) begin
      n = start ? s : STATE_WIDTH'(IDLE);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (st_i == check_enc(i)) begin
        n = mr[i] ? STATE_WIDTH'(add_enc(i)) : STATE_WIDTH'(shift_enc(i));
      end
      if (st_i == add_enc(i)) begin
        n = STATE_WIDTH'(shift_enc(i));
      end
      if (st_i == shift_enc(i)) begin
        n = (i == WIDTH - 1) ? STATE_WIDTH'(done_enc(WIDTH)) : STATE_WIDTH'(check_enc(i + 1));
      end
    end
  end

  multiplier_control_decode #(
    .WIDTH       (WIDTH),
    .STATE_WIDTH (STATE_WIDTH)
  ) u_decode (
    .s       (s),
    .mdld    (mdld),
    .mrld    (mrld),
    .rsload  (rsload),
    .rsclear (rsclear),
    .rsshr   (rsshr),
    .done    (done)
  );

endmodule

// File: tb/tb_multiplier_control.sv
// tb/tb_multiplier_control.sv - scoreboard bench for multiplier_control (WIDTH=4, STATE_WIDTH=4)
module tb_multiplier_control;

  logic       clk;
  logic       rst;
  logic [3:0] reset_state;
  logic       start;
  logic [3:0] mr;
  logic       mdld, mrld, rsload, rsclear, rsshr, done;
  logic [3:0] s, n;
  logic [5:0] outs;

  int n_cmp;
  int n_err;
  int exp_q[$];

  multiplier_control #(
    .WIDTH       (4),
    .STATE_WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reset_state (reset_state),
    .start       (start),
    .mr          (mr),
    .mdld        (mdld),
    .mrld        (mrld),
    .rsload      (rsload),
    .rsclear     (rsclear),
    .rsshr       (rsshr),
    .s           (s),
    .n           (n),
    .done        (done)
  );

  assign outs = {mdld, mrld, rsclear, rsload, rsshr, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // {mdld, mrld, rsclear, rsload, rsshr, done} expected for a W=4 state value.
  function automatic logic [5:0] exp_outs(input int st);
    case (st)
      1:             return 6'b111000;
      3, 6, 9, 12:   return 6'b000100;
      4, 7, 10, 13:  return 6'b000010;
      14:            return 6'b000001;
      default:       return 6'b000000;
    endcase
  endfunction

  // Push the expected state trace from IDLE+start through DONE.
  task automatic push_walk(input logic [3:0] mr_v);
    exp_q.push_back(1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(3 * i + 2);
      if (mr_v[i]) exp_q.push_back(3 * i + 3);
      exp_q.push_back(3 * i + 4);
    end
    exp_q.push_back(14);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int exp_edges);
    int e;
    int edges;
    edges = 0;
    while (exp_q.size() > 0 && edges < 40) begin
      tick();
      edges++;
      e = exp_q.pop_front();
      check({tag, "_s"}, 32'(s), 32'(e));
      check({tag, "_out"}, 32'(outs), 32'(exp_outs(e)));
    end
    check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
  endtask

  initial begin
    int guard;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    reset_state = 4'd0;
    start = 1'b0;
    mr = 4'd0;
    #2;
    check("rst0_s", 32'(s), 32'd0);
    check("rst0_out", 32'(outs), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    check("idle_s", 32'(s), 32'd0);
    check("idle_n", 32'(n), 32'd0);
    check("idle_out", 32'(outs), 32'd0);

    mr = 4'b0101;
    start = 1'b1;
    push_walk(mr);
    drain("walk5", 12);

    tick();
    check("done_hold_s", 32'(s), 32'd14);
    check("done_hold_out", 32'(outs), 32'b000001);
    start = 1'b0;
    #1;
    check("done_drop_n", 32'(n), 32'd0);
    tick();
    check("done_exit_s", 32'(s), 32'd0);

    reset_state = 4'd5;
    rst = 1'b1;
    mr = 4'b0010;
    #1;
    check("rs5_s", 32'(s), 32'd5);
    check("rs5_out", 32'(outs), 32'(exp_outs(5)));
    check("rs5_n_mr1", 32'(n), 32'd6);
    mr = 4'b0000;
    #1;
    check("rs5_n_mr0", 32'(n), 32'd7);

    reset_state = 4'd15;
    #1;
    check("ill_s", 32'(s), 32'd15);
    check("ill_out", 32'(outs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef MULTCTL_STATE_RECOVERY_EN
    check("ill_n", 32'(n), 32'd0);
    tick();
    check("ill_recover_s", 32'(s), 32'd0);
`else
    check("ill_n", 32'(n), 32'd15);
    tick();
    check("ill_stuck_s", 32'(s), 32'd15);
    check("ill_stuck_out", 32'(outs), 32'd0);
`endif

    reset_state = 4'd0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mr = 4'b1111;
    start = 1'b1;
    guard = 0;
    while (s != 4'd6 && guard < 20) begin
      tick();
      guard++;
    end
    check("abort_reach6_edges", 32'(guard), 32'd6);
    #1;
    rst = 1'b1;
    #1;
    check("abort_s", 32'(s), 32'd0);
    check("abort_out", 32'(outs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_walk(mr);
    drain("walk15", 14);

    start = 1'b0;
    tick();
    check("final_idle_s", 32'(s), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multiplier_control.md
# multiplier_control

Moore-style FSM that sequences a WIDTH-bit shift-and-add multiplier datapath (multiplicand register, multiplier register, running-sum register). It scans the multiplier bits LSB-first and issues load, clear, add and shift strobes, then raises `done`. The reset state is a run-time input so fault and timing campaigns can start the FSM from any encoding. Current and next state are exported for observation.

## Interface
- `WIDTH`, default 4: multiplier operand width in bits.
- `STATE_WIDTH`, default `$clog2(3*WIDTH+3)`: state register width. Must be ≥ that value.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high; loads `reset_state`.
- `reset_state`  in  STATE_WIDTH  state value loaded while `rst`=1.
- `start`  in  1  begin-multiply request, level-sensitive.
- `mr`  in  WIDTH  multiplier register contents from the datapath; not shifted by the datapath.
- `mdld`  out  1  load multiplicand register.
- `mrld`  out  1  load multiplier register.
- `rsload`  out  1  running sum ← running sum + multiplicand.
- `rsclear`  out  1  clear the running sum.
- `rsshr`  out  1  shift the running sum right by one.
- `s`  out  STATE_WIDTH  current state.
- `n`  out  STATE_WIDTH  combinational next state.
- `done`  out  1  product valid.

## Operation
- State encodings (3W+3 legal states):
  - IDLE = 0.
  - INIT = 1.
  - For bit i in 0..W-1: CHECK_i = 3i+2, ADD_i = 3i+3, SHIFT_i = 3i+4.
  - DONE = 3W+2.
  - Any value above 3W+2 is illegal.
- Transitions:
  - IDLE: `start` → INIT; otherwise stay in IDLE.
  - INIT → CHECK_0.
  - CHECK_i: `mr[i]`=1 → ADD_i; otherwise → SHIFT_i.
  - ADD_i → SHIFT_i.
  - SHIFT_i → CHECK_{i+1}; for i=W-1, → DONE.
  - DONE: `start`=1 → stay in DONE; `start`=0 → IDLE.
- Outputs are Moore, decoded from `s` only. Every output not listed below is 0.
  - INIT: `mdld`=`mrld`=`rsclear`=1.
  - ADD_i: `rsload`=1.
  - SHIFT_i: `rsshr`=1.
  - DONE: `done`=1.
  - IDLE, CHECK_i and illegal states: all strobes 0.
- `n` is the pure combinational function of `s`, `start` and `mr`.

## Timing
- While `rst`=1: `s` = `reset_state` without waiting for a clock edge, and outputs immediately reflect that decoded state.
- With `reset_state`=0, every strobe and `done` is 0 during reset.
- Reset asserted mid-operation aborts the sequence at once; there is no partial-cycle completion.
- `s` updates to `n` on each rising `clk` while `rst`=0.
- Latency, counted in edges from IDLE with `start`=1 until `s`=DONE: 2 + 2W + popcount(`mr`).
- `mr` is sampled only in CHECK states. It must be stable from INIT until DONE.
- `start` is sampled only in IDLE and DONE.
- Handshake: `done` holds until `start` falls, and a new operation needs `start` low for at least one cycle.

## Configuration
- `MULTCTL_STATE_RECOVERY_EN`:
  - Defined: an illegal `s` gives `n`=IDLE, so the FSM recovers on the next edge.
  - Undefined: an illegal `s` gives `n`=`s`, so the FSM self-loops with all outputs 0.
- In both builds every output is 0 in illegal states.

## Structure
- Shared package `multiplier_control_pkg`:
  - state constants IDLE and INIT;
  - functions for CHECK/ADD/SHIFT/DONE encodings as functions of WIDTH and i;
  - function for the legal-state count.
- One natural sub-module, `multiplier_control_decode`: combinational `s` → strobes and `done` decoder.
- The next-state logic and state register stay in the top.

## Test plan
All cases use WIDTH=4, STATE_WIDTH=4.
- `reset_state`=0, `rst` pulse, `start`=0, several clocks → `s`=0, `n`=0, all outputs 0.
- `start`=1, `mr`=4'b0101 → `s` visits 1,2,3,4,5,7,8,9,10,11,13,14 on 12 successive edges.
  - Strobes on that walk: `mdld`/`mrld`/`rsclear` only at 1; `rsload` at 3 and 9; `rsshr` at 4, 7, 10, 13; `done` at 14.
- In DONE (14) with `start`=1 → stays 14; drop `start` → next edge `s`=0.
- `reset_state`=5, assert `rst` with no clock → `s`=5.
  - With `mr`[1]=1 → `n`=6; with `mr`[1]=0 → `n`=7.
- `reset_state`=15 (illegal) → all outputs 0.
  - With `MULTCTL_STATE_RECOVERY_EN` → `n`=0, and `s`=0 after one edge.
  - Without it → `n`=15.
- `mr`=4'b1111, `start`=1, assert `rst` at `s`=6 → `s`=`reset_state` (0) immediately.
  - Rerun without interruption → `s`=14 after 14 edges.
